// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared FSM encoding and default width for the restoring divider
package seq_restoring_divider_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
    localparam int DIV_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/done handshake and operand/result bundle
interface seq_restoring_divider_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             div_by_zero;
    modport master (output start, A, B, input ready, busy, done, Q, R, div_by_zero);
    modport slave  (input start, A, B, output ready, busy, done, Q, R, div_by_zero);
endinterface

// File: rtl/seq_restoring_divider_one_bit_full_subtractor.sv
// one_bit_full_subtractor: single borrow-ripple cell computing X - Y - Bin
module one_bit_full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = X ^ Y ^ Bin;
    assign Bout = (~X & Y) | (~X & Bin) | (Y & Bin);
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic clk,
    input logic rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted, diff, rem_n;
    logic [WIDTH+1:0] bw;
    logic [WIDTH-1:0] quo_n;
    // rem stays below B, so shifting in the quotient MSB fits in WIDTH+1 bits
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign bw[0] = 1'b0;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        one_bit_full_subtractor u_fs (
            .X   (shifted[i]),
            .Y   ((i < WIDTH) ? b_q[i] : 1'b0),
            .Bin (bw[i]),
            .D   (diff[i]),
            .Bout(bw[i+1])
        );
    end
    assign rem_n = bw[WIDTH+1] ? shifted : diff;
    assign quo_n = {quo_q[WIDTH-2:0], ~bw[WIDTH+1]};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                b_d = bus.B;
                if (bus.B != '0) begin
                    rem_d   = '0;
                    quo_d   = bus.A;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    q_d     = '1;
                    r_d     = bus.A;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end
            end
            BUSY: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    q_d     = quo_n;
                    r_d     = rem_n[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end
    assign bus.ready       = (state_q == IDLE);
    assign bus.busy        = (state_q == BUSY);
    assign bus.done        = (state_q == DONE);
    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.div_by_zero = dbz_q;
endmodule
